// File: rtl/xadac_obi_mem_pkg.sv
// Shared widths and response types for the OBI subordinate memory and its response FIFO.
package xadac_obi_mem_pkg;

  localparam int unsigned ObiAddrWidth = 32;
  localparam int unsigned ObiDataWidth = 32;
  localparam int unsigned ObiIdWidth   = 4;
  localparam int unsigned ObiBeWidth   = ObiDataWidth / 8;

  typedef logic [ObiAddrWidth-1:0] SizeT;

  typedef struct packed {
    logic [ObiDataWidth-1:0] rdata;
    logic [ObiIdWidth-1:0]   rid;
    logic                    err;
  } obi_mem_rsp_t;

  localparam logic [15:0] ObiMemLfsrSeed = 16'hACE1;

  // Fibonacci LFSR, taps x^16 + x^14 + x^13 + x^11 + 1.
  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

endpackage

// File: rtl/xadac_obi_mem_if.sv
// OBI request/response bundle between a manager and the subordinate memory.
interface xadac_obi_mem_if;

  logic                                        req;
  logic                                        gnt;
  logic [xadac_obi_mem_pkg::ObiAddrWidth-1:0]  addr;
  logic                                        we;
  logic [xadac_obi_mem_pkg::ObiBeWidth-1:0]    be;
  logic [xadac_obi_mem_pkg::ObiDataWidth-1:0]  wdata;
  logic [xadac_obi_mem_pkg::ObiIdWidth-1:0]    aid;
  logic                                        rvalid;
  logic                                        rready;
  logic [xadac_obi_mem_pkg::ObiDataWidth-1:0]  rdata;
  logic [xadac_obi_mem_pkg::ObiIdWidth-1:0]    rid;
  logic                                        err;

  modport master (
    output req, addr, we, be, wdata, aid, rready,
    input  gnt, rvalid, rdata, rid, err
  );

  modport slave (
    input  req, addr, we, be, wdata, aid, rready,
    output gnt, rvalid, rdata, rid, err
  );

endinterface

// File: rtl/xadac_obi_rsp_fifo.sv
// In-order response FIFO; pointers carry an extra wrap bit so full and empty are distinct.
module xadac_obi_rsp_fifo
  import xadac_obi_mem_pkg::*;
#(
  parameter int unsigned Depth = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic         pop_i,
  input  obi_mem_rsp_t data_i,
  output obi_mem_rsp_t data_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int unsigned IdxW = (Depth > 1) ? $clog2(Depth) : 1;

  typedef logic [IdxW:0] ptr_t;

  obi_mem_rsp_t slot_q [Depth];
  ptr_t         wr_ptr_q, wr_ptr_d;
  ptr_t         rd_ptr_q, rd_ptr_d;
  logic         do_push, do_pop;

  // Index wraps at Depth-1 even when Depth is not a power of two.
  function automatic ptr_t ptr_inc(input ptr_t p);
    ptr_t n;
    if (p[IdxW-1:0] == IdxW'(Depth - 1)) n = {~p[IdxW], {IdxW{1'b0}}};
    else                                 n = p + ptr_t'(1);
    return n;
  endfunction

  assign empty_o  = (wr_ptr_q == rd_ptr_q);
  assign full_o   = (wr_ptr_q[IdxW-1:0] == rd_ptr_q[IdxW-1:0]) &&
                    (wr_ptr_q[IdxW] != rd_ptr_q[IdxW]);
  assign do_push  = push_i && !full_o;
  assign do_pop   = pop_i && !empty_o;
  assign wr_ptr_d = do_push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
  assign rd_ptr_d = do_pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
  assign data_o   = slot_q[rd_ptr_q[IdxW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < Depth; i++) slot_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      if (do_push) slot_q[wr_ptr_q[IdxW-1:0]] <= data_i;
    end
  end

endmodule

// File: rtl/xadac_obi_mem.sv
// OBI subordinate word memory with fixed-latency, in-order, backpressured responses.
// Optional grant/response stalling for handshake stress: define XADAC_OBI_MEM_STALL_EN.
module xadac_obi_mem
  import xadac_obi_mem_pkg::*;
#(
  parameter int unsigned Depth          = 1024,
  parameter SizeT        BaseAddr       = '0,
  parameter int unsigned Latency        = 1,
  parameter int unsigned MaxOutstanding = 4
) (
  input  logic           clk,
  input  logic           rst,
  xadac_obi_mem_if.slave obi
);

  localparam int unsigned ByteOffW  = $clog2(ObiBeWidth);
  localparam int unsigned IdxW      = $clog2(Depth);
  localparam int unsigned CntW      = $clog2(MaxOutstanding + 1);
  localparam SizeT        SpanBytes = SizeT'(Depth * ObiBeWidth);

  logic [ObiDataWidth-1:0] mem_q [Depth];
  logic [CntW-1:0]         outst_q, outst_d;
  SizeT                    offset;
  logic                    hit;
  logic [IdxW-1:0]         idx;
  logic                    grant, pop;
  logic                    stall_gnt, stall_pop;
  logic                    pipe_vld, fifo_full, fifo_empty;
  obi_mem_rsp_t            grant_rsp, pipe_rsp, fifo_head;

`ifdef XADAC_OBI_MEM_STALL_EN
  logic [15:0] lfsr_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) lfsr_q <= ObiMemLfsrSeed;
    else     lfsr_q <= lfsr_next(lfsr_q);
  end

  assign stall_gnt = (lfsr_q[1:0] == 2'b00);
  assign stall_pop = (lfsr_q[3:2] == 2'b00);
`else
  assign stall_gnt = 1'b0;
  assign stall_pop = 1'b0;
`endif

  // Unsigned wrap of addr-BaseAddr folds below-base addresses into the miss range.
  assign offset = obi.addr - BaseAddr;
  assign hit    = (offset < SpanBytes);
  assign idx    = offset[ByteOffW +: IdxW];

  // Registered counter only: a pop in the full cycle re-opens gnt one cycle later.
  assign obi.gnt    = obi.req && !rst && !stall_gnt && (outst_q < CntW'(MaxOutstanding));
  assign grant      = obi.req && obi.gnt;
  assign obi.rvalid = !fifo_empty && !stall_pop;
  assign pop        = obi.rvalid && obi.rready;

  always_comb begin
    grant_rsp     = '0;
    grant_rsp.rid = obi.aid;
    if (!hit)          grant_rsp.err   = 1'b1;
    else if (!obi.we)  grant_rsp.rdata = mem_q[idx];
  end

  always_ff @(posedge clk) begin
    if (grant && hit && obi.we) begin
      for (int i = 0; i < ObiBeWidth; i++) begin
        if (obi.be[i]) mem_q[idx][8*i +: 8] <= obi.wdata[8*i +: 8];
      end
    end
  end

  // The FIFO write is the last latency stage, so Latency-1 extra registers precede it.
  generate
    if (Latency > 1) begin : g_pipe
      logic [Latency-2:0] vld_q;
      obi_mem_rsp_t       rsp_q [Latency-1];

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          vld_q <= '0;
          for (int s = 0; s < Latency - 1; s++) rsp_q[s] <= '0;
        end else begin
          vld_q[0] <= grant;
          rsp_q[0] <= grant_rsp;
          for (int s = 1; s < Latency - 1; s++) begin
            vld_q[s] <= vld_q[s-1];
            rsp_q[s] <= rsp_q[s-1];
          end
        end
      end

      assign pipe_vld = vld_q[Latency-2];
      assign pipe_rsp = rsp_q[Latency-2];
    end else begin : g_nopipe
      assign pipe_vld = grant;
      assign pipe_rsp = grant_rsp;
    end
  endgenerate

  xadac_obi_rsp_fifo #(
    .Depth (MaxOutstanding)
  ) u_rsp_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (pipe_vld && !fifo_full),
    .pop_i   (pop),
    .data_i  (pipe_rsp),
    .data_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign obi.rdata = fifo_head.rdata;
  assign obi.rid   = fifo_head.rid;
  assign obi.err   = fifo_head.err;

  always_comb begin
    outst_d = outst_q;
    case ({grant, pop})
      2'b10:   outst_d = outst_q + CntW'(1);
      2'b01:   outst_d = outst_q - CntW'(1);
      default: outst_d = outst_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) outst_q <= '0;
    else     outst_q <= outst_d;
  end

endmodule

// File: tb/tb_xadac_obi_mem.sv
// Directed bench for xadac_obi_mem: stimulus pushes expected responses, a monitor pops and compares.
module tb_xadac_obi_mem;
  import xadac_obi_mem_pkg::*;

  localparam SizeT        Base  = 32'h0001_0000;
  localparam int unsigned Depth = 1024;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int errors   = 0;
  int checks   = 0;
  int cyc      = 0;
  int n_grants = 0;
  int gnt_cyc  = 0;
  logic rvalid_at_gnt = 1'b0;

  obi_mem_rsp_t sb_q[$];
  int           rsp_cyc_q[$];
  obi_mem_rsp_t mon_act, mon_exp;

  logic [31:0] bp_data [6] = '{32'h1111_1111, 32'h2222_2222, 32'h3333_3333,
                               32'h4444_4444, 32'h5555_5555, 32'h6666_6666};
  int g_cyc [6];
  int base_g, grants_at_full, pop_cyc, first_g, last_g, stale;

  xadac_obi_mem_if obi ();

  xadac_obi_mem #(
    .Depth          (Depth),
    .BaseAddr       (Base),
    .Latency        (1),
    .MaxOutstanding (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .obi (obi.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && obi.rvalid && obi.rready) begin
      mon_act.rdata = obi.rdata;
      mon_act.rid   = obi.rid;
      mon_act.err   = obi.err;
      rsp_cyc_q.push_back(cyc);
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rsp: got rdata=0x%0h rid=%0d err=%0b, expected no response (cycle %0d)",
                 obi.rdata, obi.rid, obi.err, cyc);
      end else begin
        mon_exp = sb_q.pop_front();
        chk("rsp", 64'(mon_act), 64'(mon_exp));
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 of the cycle after the grant.
  task automatic issue(input logic we, input SizeT addr, input logic [31:0] wdata,
                       input logic [3:0] be, input logic [3:0] aid,
                       input logic [31:0] exp_rdata, input logic exp_err);
    obi_mem_rsp_t e;
    logic granted = 1'b0;
    obi.req   = 1'b1;
    obi.we    = we;
    obi.addr  = addr;
    obi.wdata = wdata;
    obi.be    = be;
    obi.aid   = aid;
    for (int w = 0; w < 200 && !granted; w++) begin
      @(negedge clk);
      if (obi.gnt) granted = 1'b1;
      else begin
        @(posedge clk);
        #1;
      end
    end
    if (granted) begin
      e.rdata = exp_rdata;
      e.rid   = aid;
      e.err   = exp_err;
      sb_q.push_back(e);
      gnt_cyc       = cyc;
      rvalid_at_gnt = obi.rvalid;
      n_grants++;
      @(posedge clk);
      #1;
    end else begin
      checks++;
      errors++;
      $display("FAIL gnt_timeout: got no grant for addr 0x%0h, required a grant within 200 cycles", addr);
    end
    obi.req = 1'b0;
  endtask

  task automatic drain();
    for (int w = 0; w < 200 && sb_q.size() != 0; w++) @(negedge clk);
    if (sb_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d responses pending, required 0", sb_q.size());
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, required completion before 200000 time units");
    $fatal(1, "watchdog expired");
  end

  initial begin
    obi.req    = 1'b1;
    obi.we     = 1'b0;
    obi.addr   = '0;
    obi.be     = '0;
    obi.wdata  = '0;
    obi.aid    = '0;
    obi.rready = 1'b0;

    // Reset values, with a request pending
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_gnt",    64'(obi.gnt),    64'(0));
    chk("rst_rvalid", 64'(obi.rvalid), 64'(0));
    chk("rst_rdata",  64'(obi.rdata),  64'(0));
    chk("rst_rid",    64'(obi.rid),    64'(0));
    chk("rst_err",    64'(obi.err),    64'(0));
    @(posedge clk);
    #1;
    obi.req    = 1'b0;
    rst        = 1'b0;
    obi.rready = 1'b1;
    @(posedge clk);
    #1;

    // Write then read back, read latency of one cycle
    issue(1'b1, Base + SizeT'(8), 32'hDEAD_BEEF, 4'hF, 4'd3, 32'h0, 1'b0);
    drain();
    issue(1'b0, Base + SizeT'(8), 32'h0, 4'h0, 4'd5, 32'hDEAD_BEEF, 1'b0);
    chk("rd_rvalid_at_gnt", 64'(rvalid_at_gnt), 64'(0));
    @(negedge clk);
    chk("rd_rvalid_next", 64'(obi.rvalid), 64'(1));
    drain();

    // Byte enables
    issue(1'b1, Base, 32'h1122_3344, 4'hF,    4'd1, 32'h0, 1'b0);
    issue(1'b1, Base, 32'hAABB_CCDD, 4'b0101, 4'd2, 32'h0, 1'b0);
    issue(1'b0, Base, 32'h0,         4'h0,    4'd3, 32'h11BB_33DD, 1'b0);
    drain();

    // Misses above and below the window leave the array untouched
    issue(1'b1, Base + SizeT'(32'hFFC),   32'h55AA_55AA, 4'hF, 4'd1, 32'h0, 1'b0);
    issue(1'b0, Base + SizeT'(Depth * 4), 32'h0,         4'h0, 4'd4, 32'h0, 1'b1);
    issue(1'b1, Base - SizeT'(4),         32'hFFFF_FFFF, 4'hF, 4'd6, 32'h0, 1'b1);
    issue(1'b0, Base,                     32'h0,         4'h0, 4'd2, 32'h11BB_33DD, 1'b0);
    issue(1'b0, Base + SizeT'(32'hFFC),   32'h0,         4'h0, 4'd3, 32'h55AA_55AA, 1'b0);
    issue(1'b0, Base + SizeT'(8),         32'h0,         4'h0, 4'd9, 32'hDEAD_BEEF, 1'b0);
    drain();

    // Backpressure and full boundary
    for (int i = 0; i < 6; i++)
      issue(1'b1, Base + SizeT'(32'h10 + 4*i), bp_data[i], 4'hF, 4'(i), 32'h0, 1'b0);
    drain();
    obi.rready = 1'b0;
    base_g = n_grants;
    fork
      begin
        for (int i = 0; i < 6; i++) begin
          issue(1'b0, Base + SizeT'(32'h10 + 4*i), 32'h0, 4'h0, 4'(i), bp_data[i], 1'b0);
          g_cyc[i] = gnt_cyc;
        end
      end
      begin
        for (int w = 0; w < 50 && n_grants < base_g + 4; w++) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
          @(negedge clk);
          chk("full_gnt",     64'(obi.gnt),    64'(0));
          chk("stall_rvalid", 64'(obi.rvalid), 64'(1));
          chk("stall_rdata",  64'(obi.rdata),  64'(bp_data[0]));
          chk("stall_rid",    64'(obi.rid),    64'(0));
        end
        @(posedge clk);
        #1;
        grants_at_full = n_grants - base_g;
        obi.rready     = 1'b1;
        pop_cyc        = cyc;
        @(negedge clk);
        chk("pop_no_comb_gnt", 64'(obi.gnt), 64'(0));
      end
    join
    chk("grants_while_full", 64'(grants_at_full),      64'(4));
    chk("gnt5_after_pop",    64'(g_cyc[4] - pop_cyc), 64'(1));
    drain();

    // Throughput: 16 back-to-back reads
    for (int i = 0; i < 16; i++)
      issue(1'b1, Base + SizeT'(32'h100 + 4*i), 32'hC0DE_0000 + 32'(i), 4'hF, 4'(i), 32'h0, 1'b0);
    drain();
    rsp_cyc_q.delete();
    for (int i = 0; i < 16; i++) begin
      issue(1'b0, Base + SizeT'(32'h100 + 4*i), 32'h0, 4'h0, 4'(i), 32'hC0DE_0000 + 32'(i), 1'b0);
      if (i == 0) first_g = gnt_cyc;
    end
    last_g = gnt_cyc;
    drain();
    chk("tput_grant_span", 64'(last_g - first_g),   64'(15));
    chk("tput_rsp_count",  64'(rsp_cyc_q.size()),  64'(16));
    if (rsp_cyc_q.size() >= 16) begin
      chk("tput_rsp_span",  64'(rsp_cyc_q[15] - rsp_cyc_q[0]), 64'(15));
      chk("tput_first_rsp", 64'(rsp_cyc_q[0] - first_g),      64'(1));
    end

    // Reset with a write and three reads in flight
    obi.rready = 1'b0;
    issue(1'b1, Base + SizeT'(32'h200), 32'h0BAD_F00D, 4'hF, 4'd7, 32'h0, 1'b0);
    for (int i = 0; i < 3; i++)
      issue(1'b0, Base, 32'h0, 4'h0, 4'(8 + i), 32'h11BB_33DD, 1'b0);
    obi.req  = 1'b1;
    obi.we   = 1'b0;
    obi.addr = Base;
    rst      = 1'b1;
    @(negedge clk);
    chk("rst_mid_rvalid", 64'(obi.rvalid), 64'(0));
    chk("rst_mid_gnt",    64'(obi.gnt),    64'(0));
    sb_q.delete();
    @(posedge clk);
    #1;
    rst        = 1'b0;
    obi.req    = 1'b0;
    obi.rready = 1'b1;
    stale = 0;
    repeat (5) begin
      @(negedge clk);
      if (obi.rvalid) stale++;
    end
    chk("no_stale_rsp", 64'(stale), 64'(0));
    @(posedge clk);
    #1;
    issue(1'b0, Base + SizeT'(32'h200), 32'h0, 4'h0, 4'd11, 32'h0BAD_F00D, 1'b0);
    drain();

    chk("sb_empty", 64'(sb_q.size()), 64'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/xadac_obi_mem.md
Name: xadac_obi_mem

Overview:
OBI subordinate memory model and responder: the far end of the accelerator's OBI manager port.
- Accepts address-phase requests and performs word-wide reads/writes with byte enables on an internal array.
- Returns in-order responses after a fixed latency through a response buffer that honours rready backpressure.
- Used as the data memory behind the OBI mux in unit/system benches and as a small scratchpad in FPGA builds.

Parameters:
- Depth, 1024, number of DataWidth words in the array (power of two).
- BaseAddr, 32'h0000_0000, byte address of word 0; must be aligned to Depth*DataWidth/8.
- Latency, 1, cycles from grant to earliest rvalid (>=1).
- MaxOutstanding, 4, maximum granted-but-unretired transactions; also the response FIFO depth.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- obi  modport  OBI_BUS.Subordinate (ObiCfg)  fields used: req, gnt, addr, we, be, wdata, aid, rvalid, rready, rdata, rid, err.

Behaviour:
- Reset is asynchronous, active-high.
- Reset values: gnt=0, rvalid=0, rdata=0, rid=0, err=0.
  - Outstanding counter, latency pipeline valid bits and FIFO pointers are cleared.
  - Array contents are not reset.
- Reset mid-operation drops all in-flight responses.
  - A write granted before reset has already been committed.
- Grant: gnt = req && (outstanding < MaxOutstanding). Combinational on req.
  - Address phase completes on req && gnt.
  - Request fields must be stable while req && !gnt (bench checks; the block does not).
- Decode: hit = (addr - BaseAddr) < Depth*DataWidth/8. Word index = (addr - BaseAddr) >> log2(DataWidth/8). Low byte-offset bits are ignored.
- Write (we=1, hit): each byte lane i with be[i]=1 is updated at the grant edge. The response carries rdata=0, err=0.
- Read (we=0, hit): array word captured at the grant edge. A write granted in an earlier cycle is visible (read-after-write ordering).
- Miss (either direction): no array access; response has err=1, rdata=0.
- Response path: the granted response {rdata, rid=aid, err} enters a Latency-stage valid pipeline, then the FIFO.
  - rvalid = FIFO non-empty. Pop on rvalid && rready.
  - With Latency=1 and an empty FIFO, rvalid rises the cycle after grant.
  - While rvalid && !rready, rdata/rid/err are held stable.
- Outstanding counter: +1 on grant, -1 on pop. Simultaneous grant and pop leaves it unchanged.
  - Capping at MaxOutstanding guarantees the FIFO never overflows, so no drop path exists.
- Ordering: responses are strictly in grant order, independent of aid.
- Back-to-back grants every cycle are supported while rready=1. Sustained throughput is 1 transaction/cycle.
- Full boundary: at outstanding==MaxOutstanding, gnt=0 even with req=1.
  - A pop in that cycle does not combinationally raise gnt. gnt returns the following cycle.
- FIFO pointers wrap modulo MaxOutstanding. Full/empty are distinguished by an extra pointer bit.

Optional Feature:
- Macro XADAC_OBI_MEM_STALL_EN.
- Defined:
  - A 16-bit LFSR (seed 16'hACE1 on reset, x^16+x^14+x^13+x^11+1) advances every cycle.
  - gnt is additionally masked when lfsr[1:0]==2'b00.
  - A pipeline-exit/pop is also stalled (rvalid forced 0) when lfsr[3:2]==2'b00.
  - Purpose: stressing manager handshakes. Data and ordering are unchanged.
- Undefined: no LFSR logic. Grant and rvalid follow the base rules exactly.

Decomposition:
- xadac_pkg additions:
  - obi_mem_rsp_t struct {rdata, rid, err}.
  - constant ObiMemLfsrSeed.
  - Existing ObiCfg and SizeT are reused for widths.
- One natural sub-module: xadac_obi_rsp_fifo.
  - Synchronous FIFO of obi_mem_rsp_t, depth MaxOutstanding.
  - push/pop, full/empty, pointer wrap.
- The array, decode, latency pipeline and counter stay in the top.

Test Plan:
- Write/readback: write 32'hDEADBEEF to BaseAddr+8, be=4'hF, aid=3; read same addr aid=5 -> responses in order: (rdata=0, rid=3, err=0), then (rdata=32'hDEADBEEF, rid=5, err=0); read rvalid exactly 1 cycle after its grant with Latency=1.
- Byte enables: preload 32'h11223344 at BaseAddr; write 32'hAABBCCDD with be=4'b0101; read -> 32'h11BB33DD.
- Miss: read BaseAddr+Depth*4 and write BaseAddr-4 -> both err=1, rdata=0; a subsequent read of BaseAddr+0 shows no array word changed.
- Backpressure/full: rready=0, issue 6 reads with req held -> exactly 4 grants, then gnt=0. Raise rready -> 4 responses in issue order with stable data while stalled. The 5th grant occurs the cycle after the first pop.
- Throughput: rready=1, 16 consecutive reads to incrementing addresses -> 16 grants in 16 cycles, rvalid continuous for 16 cycles, correct data per address.
- Reset mid-flight: 3 reads outstanding, pulse rst for 1 cycle -> rvalid=0 and gnt=0 during reset; after reset no stale responses emerge. A write granted pre-reset is readable post-reset.
